// File: rtl/ledsg_seq.sv
// Avalon-MM LED pattern sequencer: plays up to 8 stored patterns into the LED block.
// Optional macro LEDSEQ_BLANK_ON_STOP_EN adds a final 8'h00 write on stop/completion.
module ledsg_seq #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned LED_ADDR = 0
) (
  input  logic        csi_clk,
  input  logic        csi_reset_n,
  input  logic [3:0]  avs_s1_address,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  input  logic        avs_s1_read,
  output logic [31:0] avs_s1_readdata,
  output logic [3:0]  avm_m1_address,
  output logic        avm_m1_write,
  output logic [7:0]  avm_m1_writedata,
  input  logic        avm_m1_waitrequest
);

`ifdef LEDSEQ_BLANK_ON_STOP_EN
  typedef enum logic [1:0] {IDLE, WRITE, HOLD, BLANK} state_e;
`else
  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_e;
`endif

  state_e              state_q;
  logic                run_q, loop_q, done_q;
  logic [PERIOD_W-1:0] period_q, cnt_q;
  logic [2:0]          length_q, index_q;
  logic [7:0]          pat_q [8];
  logic                wr_q;
  logic [7:0]          wdata_q;
`ifdef LEDSEQ_BLANK_ON_STOP_EN
  logic                blank_done_q;
`endif

  logic                ctrl_wr, run_eff, done_clr, last_step, busy;
  logic [PERIOD_W-1:0] period_m1;
  logic [2:0]          index_nx;
  logic                unused_wdata;

  assign ctrl_wr   = avs_s1_write && (avs_s1_address == 4'd0);
  // A CTRL write in the current cycle overrides RUN so a stop takes effect one clock later
  assign run_eff   = ctrl_wr ? avs_s1_writedata[0] : run_q;
  assign done_clr  = ctrl_wr && (avs_s1_writedata[2] || avs_s1_writedata[0]);
  assign last_step = (index_q == length_q) || (index_q == 3'd7);
  assign index_nx  = index_q + 3'd1;
  assign period_m1 = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
  assign busy      = (state_q != IDLE);

  assign avm_m1_address   = 4'(LED_ADDR);
  assign avm_m1_write     = wr_q;
  assign avm_m1_writedata = wdata_q;
  assign unused_wdata     = ^avs_s1_writedata;

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      done_q   <= 1'b0;
      period_q <= '0;
      cnt_q    <= '0;
      length_q <= '0;
      index_q  <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      for (int unsigned i = 0; i < 8; i++) pat_q[i] <= '0;
`ifdef LEDSEQ_BLANK_ON_STOP_EN
      blank_done_q <= 1'b0;
`endif
    end else begin
      if (avs_s1_write) begin
        case (avs_s1_address)
          4'd0: begin
            run_q  <= avs_s1_writedata[0];
            loop_q <= avs_s1_writedata[1];
          end
          4'd1: period_q <= avs_s1_writedata[PERIOD_W-1:0];
          4'd2: length_q <= avs_s1_writedata[2:0];
          default: if (avs_s1_address[3]) pat_q[avs_s1_address[2:0]] <= avs_s1_writedata[7:0];
        endcase
      end
      if (done_clr) done_q <= 1'b0;

      // FSM assignments follow the register writes so completion wins over a same-cycle clear
      case (state_q)
        IDLE: begin
          if (run_eff) begin
            index_q <= '0;
            wdata_q <= pat_q[0];
            wr_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (!avm_m1_waitrequest) begin
            wr_q <= 1'b0;
            if (!run_eff) begin
`ifdef LEDSEQ_BLANK_ON_STOP_EN
              wr_q         <= 1'b1;
              wdata_q      <= '0;
              blank_done_q <= 1'b0;
              state_q      <= BLANK;
`else
              state_q <= IDLE;
`endif
            end else begin
              cnt_q   <= period_m1;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!run_eff) begin
`ifdef LEDSEQ_BLANK_ON_STOP_EN
            wr_q         <= 1'b1;
            wdata_q      <= '0;
            blank_done_q <= 1'b0;
            state_q      <= BLANK;
`else
            state_q <= IDLE;
`endif
          end else if (cnt_q == '0) begin
            if (!last_step) begin
              index_q <= index_nx;
              wdata_q <= pat_q[index_nx];
              wr_q    <= 1'b1;
              state_q <= WRITE;
            end else if (loop_q) begin
              index_q <= '0;
              wdata_q <= pat_q[0];
              wr_q    <= 1'b1;
              state_q <= WRITE;
            end else begin
              run_q <= 1'b0;
`ifdef LEDSEQ_BLANK_ON_STOP_EN
              wr_q         <= 1'b1;
              wdata_q      <= '0;
              blank_done_q <= 1'b1;
              state_q      <= BLANK;
`else
              done_q  <= 1'b1;
              state_q <= IDLE;
`endif
            end
          end else begin
            cnt_q <= cnt_q - PERIOD_W'(1);
          end
        end
`ifdef LEDSEQ_BLANK_ON_STOP_EN
        BLANK: begin
          if (!avm_m1_waitrequest) begin
            wr_q    <= 1'b0;
            run_q   <= 1'b0;
            state_q <= IDLE;
            if (blank_done_q) done_q <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    avs_s1_readdata = '0;
    if (avs_s1_read) begin
      case (avs_s1_address)
        4'd0: begin
          avs_s1_readdata[0] = run_q;
          avs_s1_readdata[1] = loop_q;
          avs_s1_readdata[8] = busy;
          avs_s1_readdata[9] = done_q;
        end
        4'd1: avs_s1_readdata[PERIOD_W-1:0] = period_q;
        4'd2: avs_s1_readdata[2:0] = length_q;
        4'd3: avs_s1_readdata[2:0] = index_q;
        default: if (avs_s1_address[3]) avs_s1_readdata[7:0] = pat_q[avs_s1_address[2:0]];
      endcase
    end
  end

endmodule

// File: tb/tb_ledsg_seq.sv
// Directed bench for ledsg_seq (default build): sequencing, loop/stop, stall, PERIOD=0, reset.
module tb_ledsg_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_addr = '0;
  logic        s_wr = 1'b0;
  logic [31:0] s_wdata = '0;
  logic        s_rd = 1'b0;
  logic [31:0] s_rdata;
  logic [3:0]  m_addr;
  logic        m_wr;
  logic [7:0]  m_wdata;
  logic        m_wait = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] q_data[$];
  int         q_cyc[$];

  ledsg_seq #(.PERIOD_W(24), .LED_ADDR(0)) dut (
    .csi_clk(clk), .csi_reset_n(rst_n),
    .avs_s1_address(s_addr), .avs_s1_write(s_wr), .avs_s1_writedata(s_wdata),
    .avs_s1_read(s_rd), .avs_s1_readdata(s_rdata),
    .avm_m1_address(m_addr), .avm_m1_write(m_wr), .avm_m1_writedata(m_wdata),
    .avm_m1_waitrequest(m_wait)
  );

  always #5 clk = ~clk;

  // Record every accepted master transfer with its cycle number
  always @(posedge clk) begin
    if (m_wr && !m_wait) begin
      q_data.push_back(m_wdata);
      q_cyc.push_back(cyc);
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write spans one posedge and returns at the next negedge
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    s_addr = a; s_wdata = d; s_wr = 1'b1;
    @(negedge clk);
    s_wr = 1'b0; s_addr = '0; s_wdata = '0;
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    s_addr = a; s_rd = 1'b1;
    #1 d = s_rdata;
    s_rd = 1'b0; s_addr = '0;
    chk(tag, d, exp);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    logic [31:0] d;
    d = 32'h100;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      s_addr = 4'd0; s_rd = 1'b1;
      #1 d = s_rdata;
      s_rd = 1'b0;
      if (!d[8]) break;
    end
    chk(tag, 32'(d[8]), 32'd0);
  endtask

  function automatic logic [31:0] qd(input int i);
    return (i < q_data.size()) ? 32'(q_data[i]) : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] qgap(input int i);
    return (i < q_cyc.size()) ? 32'(q_cyc[i] - q_cyc[i-1]) : 32'hxxxxxxxx;
  endfunction

  initial begin
    logic [7:0] exp_pat [4];
    exp_pat[0] = 8'h01; exp_pat[1] = 8'h02; exp_pat[2] = 8'h04; exp_pat[3] = 8'h08;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr", 32'(m_wr), 32'd0);
    chk("rst_wdata", 32'(m_wdata), 32'd0);
    chk("rst_addr", 32'(m_addr), 32'd0);
    chk_rd("rst_ctrl", 4'd0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-shot sequence 01,02,04,08 at PERIOD=3
    for (int i = 0; i < 4; i++) bus_wr(4'(8 + i), 32'(exp_pat[i]));
    bus_wr(4'd1, 32'd3);
    bus_wr(4'd2, 32'd3);
    chk_rd("period_rb", 4'd1, 32'd3);
    chk_rd("length_rb", 4'd2, 32'd3);
    chk_rd("pat2_rb", 4'd10, 32'h04);
    chk_rd("unmapped_rb", 4'd5, 32'h0);
    q_data.delete(); q_cyc.delete();
    bus_wr(4'd0, 32'h1);
    chk("start_lat", {23'd0, m_wr, m_wdata}, {23'd0, 1'b1, 8'h01});
    wait_idle("t1_timeout", 60);
    chk("t1_count", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_data%0d", i), qd(i), 32'(exp_pat[i]));
    for (int i = 1; i < 4; i++) chk($sformatf("t1_gap%0d", i), qgap(i), 32'd4);
    chk_rd("t1_ctrl", 4'd0, 32'h200);
    chk_rd("t1_step", 4'd3, 32'd3);

    // Looping run, then software stop during HOLD
    q_data.delete(); q_cyc.delete();
    bus_wr(4'd0, 32'h3);
    chk_rd("t2_ctrl_run", 4'd0, 32'h103);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (q_data.size() >= 5) break;
    end
    bus_wr(4'd0, 32'h2);
    chk_rd("t2_ctrl_stop", 4'd0, 32'h002);
    repeat (12) @(negedge clk);
    chk("t2_count", 32'(q_data.size()), 32'd5);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_data%0d", i), qd(i), 32'(exp_pat[i]));
    chk("t2_wrap", qd(4), 32'h01);
    chk("t2_gap_wrap", qgap(4), 32'd4);
    chk_rd("t2_step", 4'd3, 32'd0);

    // Stalled first write: 5 waitrequest cycles, then a PERIOD=2 hold
    bus_wr(4'd8, 32'hAA);
    bus_wr(4'd2, 32'd0);
    bus_wr(4'd1, 32'd2);
    q_data.delete(); q_cyc.delete();
    m_wait = 1'b1;
    bus_wr(4'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("t3_stall%0d", k), {23'd0, m_wr, m_wdata}, {23'd0, 1'b1, 8'hAA});
      if (k == 6) m_wait = 1'b0;
      @(negedge clk);
    end
    chk("t3_wr_drop", 32'(m_wr), 32'd0);
    chk_rd("t3_hold1", 4'd0, 32'h101);
    @(negedge clk);
    chk_rd("t3_hold0", 4'd0, 32'h101);
    @(negedge clk);
    chk_rd("t3_done", 4'd0, 32'h200);
    chk("t3_count", 32'(q_data.size()), 32'd1);

    // PERIOD=0 behaves as 1
    bus_wr(4'd8, 32'hFF);
    bus_wr(4'd1, 32'd0);
    q_data.delete(); q_cyc.delete();
    bus_wr(4'd0, 32'h1);
    chk("t4_write", {23'd0, m_wr, m_wdata}, {23'd0, 1'b1, 8'hFF});
    @(negedge clk);
    chk_rd("t4_hold", 4'd0, 32'h101);
    @(negedge clk);
    chk_rd("t4_done", 4'd0, 32'h200);
    chk("t4_data", qd(0), 32'hFF);
    chk("t4_count", 32'(q_data.size()), 32'd1);

    // Asynchronous reset during a stalled write
    bus_wr(4'd8, 32'h55);
    bus_wr(4'd1, 32'd7);
    m_wait = 1'b1;
    bus_wr(4'd0, 32'h3);
    @(negedge clk);
    chk("t5_stalled", {23'd0, m_wr, m_wdata}, {23'd0, 1'b1, 8'h55});
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wr", 32'(m_wr), 32'd0);
    chk("t5_rst_wdata", 32'(m_wdata), 32'd0);
    chk_rd("t5_rst_ctrl", 4'd0, 32'h0);
    chk_rd("t5_rst_period", 4'd1, 32'h0);
    chk_rd("t5_rst_pat0", 4'd8, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_wait = 1'b0;
    @(negedge clk);
    chk("t5_post_wr", 32'(m_wr), 32'd0);
    chk_rd("t5_post_ctrl", 4'd0, 32'h0);
    chk_rd("t5_post_step", 4'd3, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ledsg_seq.md
Name: ledsg_seq

Overview:
- Avalon-MM pattern sequencer that drives the 8-bit LED segment register block through an Avalon-MM master port.
- Software loads up to 8 LED patterns, a step period and a sequence length through the slave port, then sets RUN.
- The block writes each pattern to the LED block in turn, holds it for PERIOD clocks, and then either stops or loops.
- It sits between the CPU interconnect and the LED register block, taking over updates the CPU would otherwise do one by one.

Parameters:
- PERIOD_W, 24, width of the PERIOD register and the hold counter.
- LED_ADDR, 0, constant word address driven on avm_m1_address.

Ports:
- csi_clk  in  1  system clock
- csi_reset_n  in  1  reset, asynchronous, active-low
- avs_s1_address  in  4  slave word address
- avs_s1_write  in  1  slave write strobe
- avs_s1_writedata  in  32  slave write data
- avs_s1_read  in  1  slave read strobe
- avs_s1_readdata  out  32  slave read data, zero wait states
- avm_m1_address  out  4  master address, always LED_ADDR
- avm_m1_write  out  1  master write request
- avm_m1_writedata  out  8  LED pattern being written
- avm_m1_waitrequest  in  1  master stall from the LED block

Behaviour:
- Reset is csi_reset_n, asynchronous, active-low; the clock is csi_clk.
- In reset, all registers clear:
  - CTRL=0, PERIOD=0, LENGTH=0, patterns=0, index=0, counter=0, done=0.
  - avm_m1_write=0, avm_m1_writedata=0, state=IDLE.
- Register map (word address):
  - 0 CTRL. Write: bit0 RUN, bit1 LOOP, bit2 CLR_DONE (pulse). Read: bit0 RUN, bit1 LOOP, bit8 BUSY (state!=IDLE), bit9 DONE.
  - 1 PERIOD[PERIOD_W-1:0]: clocks per step. 0 is treated as 1.
  - 2 LENGTH[2:0]: last step index; steps = LENGTH+1.
  - 3 STEP: read-only current index[2:0].
  - 8..15 PATTERN0..7[7:0].
  - Unmapped addresses read 0 and ignore writes.
  - Unused readdata bits read 0.
- Reads are combinational on avs_s1_address; avs_s1_read only qualifies the access.
- State machine (one-hot or encoded):
  - IDLE: when RUN=1, index<=0 and go to WRITE. A CTRL write with RUN=1 at cycle N gives avm_m1_write=1 at cycle N+1.
  - WRITE:
    - Drive avm_m1_write=1 and avm_m1_writedata=PATTERN[index].
    - Hold address, data and write stable while waitrequest=1.
    - On the cycle waitrequest=0, the transfer completes: load counter=max(PERIOD,1)-1 and go to HOLD.
  - HOLD: decrement counter each clock. When counter==0:
    - If index!=LENGTH: index+1, go to WRITE.
    - Else if LOOP: index=0, go to WRITE.
    - Else: DONE<=1, RUN<=0, go to IDLE.
- Step-to-step spacing at the LED block is exactly max(PERIOD,1)+1 clocks when waitrequest stays 0.
- Software stop (RUN cleared):
  - In HOLD: go to IDLE next cycle; index is kept for STEP readback.
  - In WRITE: the pending transfer must complete (the write is never withdrawn under waitrequest), then go to IDLE.
- Setting RUN while BUSY has no effect. LOOP may change at any time and is sampled at the end of the last step.
- PERIOD writes take effect at the next counter load.
- PATTERN writes take effect at the next WRITE of that index. The pattern value is captured on entry to WRITE.
- DONE clears on CLR_DONE or on a CTRL write with RUN=1. If a completion and a clear happen in the same cycle, completion wins (DONE=1).
- LENGTH is sampled continuously. If it is lowered below the current index, the sequence runs on to index 7 before the wrap/stop decision.
- Reset mid-transfer drops avm_m1_write immediately; this is permitted on reset.

Optional Feature:
- Macro LEDSEQ_BLANK_ON_STOP_EN.
- Defined: on a software stop, or on non-loop completion, the block enters a BLANK state that issues one final master write of 8'h00 (same waitrequest rules) before IDLE. BUSY stays 1 until that write completes, and DONE is set when BLANK completes.
- Undefined: there is no BLANK state, and the LEDs keep the last pattern.

Test Plan:
- PATTERN0..3=01,02,04,08, PERIOD=3, LENGTH=3, LOOP=0, RUN=1, waitrequest=0 -> master writes 01,02,04,08 spaced 4 clocks apart; then DONE=1, BUSY=0, RUN=0, STEP=3.
- Same setup with LOOP=1 -> the sequence repeats 01..08,01 with the same spacing. Clearing RUN during HOLD -> no further writes, BUSY=0 the next clock.
- waitrequest held high 5 clocks on the first write of AA -> avm_m1_write and writedata AA held stable for 6 cycles; the hold counter starts only after acceptance.
- PERIOD=0, LENGTH=0, PATTERN0=FF -> one write of FF, HOLD lasts 1 clock, then DONE=1.
- Reset asserted during a stalled write -> avm_m1_write=0 and all registers read 0 immediately. After release, a register readback gives CTRL=0 and STEP=0.
- With LEDSEQ_BLANK_ON_STOP_EN defined: run 01,02 with LOOP=0 -> master writes 01, 02, 00; DONE is set only after the 00 write completes.
